// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: each channel divides clk by its own
// runtime ratio, with ratio changes deferred to a period boundary.
module clk_div_prog #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_restart,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic             wr_valid;
  logic [CNT_W-1:0] wr_div;

  // Ratios 0 and 1 are meaningless for a divider, so they are treated as 2.
  assign wr_valid = cfg_we && (32'(cfg_ch) < 32'(NUM_CH));
  assign wr_div   = (cfg_div < TWO) ? TWO : cfg_div;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] d_act_r;
    logic [CNT_W-1:0] shadow_r;
    logic             pending_r;
    logic             clk_out_r;
    logic             tick_r;
    logic [CNT_W-1:0] half_hi;
    logic             wrap;
    logic             wr_hit;

    // High phase is the ceiling half, so odd ratios run one cycle longer high.
    assign half_hi = d_act_r - (d_act_r >> 1);
    assign wrap    = (cnt_r == (d_act_r - ONE));
    assign wr_hit  = wr_valid && (cfg_ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_r     <= '0;
        d_act_r   <= DEF;
        shadow_r  <= DEF;
        pending_r <= 1'b0;
        clk_out_r <= 1'b0;
        tick_r    <= 1'b0;
      end else if (sync_restart) begin
        // A write landing in the restart cycle goes straight into the active ratio.
        cnt_r     <= '0;
        clk_out_r <= 1'b1;
        tick_r    <= en[i];
        pending_r <= 1'b0;
        if (wr_hit) begin
          d_act_r  <= wr_div;
          shadow_r <= wr_div;
        end else begin
          d_act_r  <= shadow_r;
        end
      end else begin
        if (en[i]) begin
          if (wrap) begin
            cnt_r     <= '0;
            clk_out_r <= 1'b1;
            tick_r    <= 1'b1;
            if (pending_r) begin
              d_act_r   <= shadow_r;
              pending_r <= 1'b0;
            end
          end else begin
            cnt_r     <= cnt_r + ONE;
            clk_out_r <= ((cnt_r + ONE) < half_hi);
            tick_r    <= 1'b0;
          end
        end else begin
          tick_r <= 1'b0;
        end
        // Placed after the wrap update so a same-cycle write stays pending.
        if (wr_hit) begin
          shadow_r  <= wr_div;
          pending_r <= 1'b1;
        end
      end
    end

    assign cfg_pending[i] = pending_r;
    assign clk_out[i]     = clk_out_r;
    assign tick[i]        = tick_r;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed test-plan steps plus random traffic, checked
// every cycle against a per-period waveform model.
module tb_clk_div_prog;

  localparam int NC  = 4;
  localparam int W   = 8;
  localparam int DEF = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] en;
  logic          sync_restart;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_div;
  logic [NC-1:0] cfg_pending;
  logic [NC-1:0] clk_out;
  logic [NC-1:0] tick;

  // Three-channel instance used only to exercise out-of-range channel writes.
  logic          cfg_we3;
  logic [1:0]    cfg_ch3;
  logic [W-1:0]  cfg_div3;
  logic [2:0]    pend3;
  logic [2:0]    clk3;
  logic [2:0]    tick3;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // clock/reset block
  always #5 clk = ~clk;

  clk_div_prog #(.NUM_CH(NC), .CNT_W(W), .DEF_DIV(DEF)) u_dut (
    .clk(clk), .reset(reset), .en(en), .sync_restart(sync_restart),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_pending(cfg_pending), .clk_out(clk_out), .tick(tick)
  );

  clk_div_prog #(.NUM_CH(3), .CNT_W(W), .DEF_DIV(DEF)) u_dut3 (
    .clk(clk), .reset(reset), .en(3'b111), .sync_restart(1'b0),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3),
    .cfg_pending(pend3), .clk_out(clk3), .tick(tick3)
  );

  // Reference model: each channel keeps a queue of the clk_out values still
  // to come in its current period; an empty queue means the next edge is a rise.
  int m_d   [NC];
  int m_sh  [NC];
  bit m_pend[NC];
  bit m_out [NC];
  bit m_tick[NC];
  bit m_q   [NC][$];
  int r3;

  function automatic void refill(int ch);
    int d;
    d = m_d[ch];
    m_q[ch].delete();
    for (int k = 1; k < d; k++) m_q[ch].push_back(k < (d - d / 2));
  endfunction

  function automatic void model_update();
    bit wr_ok;
    int wv;
    wr_ok = cfg_we && (int'(cfg_ch) < NC);
    wv    = (cfg_div < 2) ? 2 : int'(cfg_div);
    r3    = reset ? 0 : r3 + 1;
    for (int ch = 0; ch < NC; ch++) begin
      bit hit;
      hit = wr_ok && (int'(cfg_ch) == ch);
      if (reset) begin
        m_d[ch] = DEF; m_sh[ch] = DEF; m_pend[ch] = 0;
        m_out[ch] = 0; m_tick[ch] = 0;
        refill(ch);
      end else if (sync_restart) begin
        if (hit) m_sh[ch] = wv;
        m_d[ch] = m_sh[ch]; m_pend[ch] = 0;
        m_out[ch] = 1; m_tick[ch] = en[ch];
        refill(ch);
      end else begin
        if (en[ch]) begin
          if (m_q[ch].size() == 0) begin
            m_out[ch] = 1; m_tick[ch] = 1;
            if (m_pend[ch]) begin m_d[ch] = m_sh[ch]; m_pend[ch] = 0; end
            refill(ch);
          end else begin
            m_out[ch] = m_q[ch].pop_front(); m_tick[ch] = 0;
          end
        end else begin
          m_tick[ch] = 0;
        end
        if (hit) begin m_sh[ch] = wv; m_pend[ch] = 1; end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NC-1:0] e_out, e_tick, e_pend;
    logic [2:0]    e3;
    for (int ch = 0; ch < NC; ch++) begin
      e_out[ch]  = m_out[ch];
      e_tick[ch] = m_tick[ch];
      e_pend[ch] = m_pend[ch];
    end
    // The side instance only ever sees ignored writes, so it stays a /2.
    e3 = (r3 > 0 && (r3 % 2) == 0) ? 3'b111 : 3'b000;
    chk("clk_out", 32'(clk_out), 32'(e_out));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("cfg_pending", 32'(cfg_pending), 32'(e_pend));
    chk("oor_clk_out", 32'(clk3), 32'(e3));
    chk("oor_tick", 32'(tick3), 32'(e3));
    chk("oor_pending", 32'(pend3), 32'(0));
  endtask

  // driver: inputs are changed on the falling edge, one cycle per call
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
    cfg_we = 1'b0; sync_restart = 1'b0; cfg_we3 = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input int ch, input int div);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = W'(div);
    step();
  endtask

  initial begin
    reset = 1'b1; en = '1; sync_restart = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_we3 = 1'b0; cfg_ch3 = 2'd3; cfg_div3 = '0;

    run(2);
    chk("rst_clk_out", 32'(clk_out), 32'(0));
    chk("rst_pending", 32'(cfg_pending), 32'(0));
    reset = 1'b0;
    step();
    chk("first_edge_low", 32'(clk_out), 32'(0));
    step();
    chk("first_rise", 32'(clk_out), 32'hF);
    chk("first_tick", 32'(tick), 32'hF);
    run(4);

    // ch1 to /3
    write(1, 3);
    run(12);

    // ch0: long period, then two quick writes; only the last should apply
    write(0, 10);
    run(12);
    write(0, 5);
    write(0, 8);
    run(24);
    write(0, 0);
    run(8);

    // ch2 /4 and ch3 /6, then phase-align
    write(2, 4);
    write(3, 6);
    run(15);
    sync_restart = 1'b1;
    step();
    chk("restart_rise", 32'(clk_out), 32'hF);
    chk("restart_tick", 32'(tick), 32'hF);
    run(14);

    // freeze ch1 for five cycles then resume
    write(1, 7);
    run(8);
    en[1] = 1'b0;
    run(5);
    en[1] = 1'b1;
    run(10);

    // restart with a same-cycle write that bypasses into the active ratio
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = W'(5); sync_restart = 1'b1;
    step();
    run(12);

    // reset mid-period discards a pending write
    write(2, 7);
    reset = 1'b1;
    step();
    chk("rst_mid_clk_out", 32'(clk_out), 32'(0));
    chk("rst_mid_tick", 32'(tick), 32'(0));
    chk("rst_mid_pending", 32'(cfg_pending), 32'(0));
    reset = 1'b0;
    step();
    step();
    chk("rst_discard_rise", 32'(clk_out), 32'hF);

    // out-of-range write on the three-channel instance
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = W'(5);
    step();
    run(6);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 5) == 0) ? NC'($urandom) : '1;
      if ($urandom_range(0, 5) == 0) begin
        cfg_we = 1'b1;
        cfg_ch = 2'($urandom_range(0, NC - 1));
        cfg_div = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 1))
                                              : W'($urandom_range(2, 9));
      end
      sync_restart = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 6) == 0) begin
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = W'($urandom);
      end
      step();
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
